// File: rtl/serial_to_parallel_converter.sv
// Assembles MSB-first serial bits, qualified by a per-bit strobe, into DATA_WIDTH-bit words.
// Presents each word through a one-entry valid/ready output register with sticky frame and overrun flags.
module serial_to_parallel_converter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serialDataIn,
  input  logic                  serialValid,
  input  logic                  frameStart,
  output logic [DATA_WIDTH-1:0] parallelDataOut,
  output logic                  parallelValid,
  input  logic                  parallelReady,
  output logic                  busy,
  output logic                  frameError,
  output logic                  overrunError,
  input  logic                  clearErrors
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    overrun_err_q, overrun_err_d;

  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   first_bit;
  logic                    word_done;
  logic                    frame_set;
  logic                    overrun_set;

  assign shifted   = {shift_q[DATA_WIDTH-2:0], serialDataIn};
  assign first_bit = {{(DATA_WIDTH-1){1'b0}}, serialDataIn};

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    frame_set = 1'b0;

    if (serialValid) begin
      unique case (state_q)
        IDLE: begin
          if (frameStart) begin
            shift_d = first_bit;
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (frameStart) begin
            // A resync mid-word aborts the partial word and starts a new one with this bit.
            frame_set = 1'b1;
            shift_d   = first_bit;
            cnt_d     = CW'(1);
          end else if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            word_done = 1'b1;
            shift_d   = shifted;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            shift_d = shifted;
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_set = 1'b0;

    if (word_done) begin
      // The slot is free if empty or being drained on this same edge.
      if (!valid_q || parallelReady) begin
        data_d  = shifted;
        valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (valid_q && parallelReady) begin
      valid_d = 1'b0;
    end

    frame_err_d   = frame_set   | (frame_err_q   & ~clearErrors);
    overrun_err_d = overrun_set | (overrun_err_q & ~clearErrors);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign parallelDataOut = data_q;
  assign parallelValid   = valid_q;
  assign busy            = (state_q == SHIFT);
  assign frameError      = frame_err_q;
  assign overrunError    = overrun_err_q;

endmodule

// File: tb/tb_serial_to_parallel_converter.sv
// Directed bench for serial_to_parallel_converter: inputs change on negedge, outputs are checked
// on the following negedge, with hand-computed expected words and flags.
module tb_serial_to_parallel_converter;

  logic       clk = 1'b0;
  logic       reset;
  logic       serialDataIn;
  logic       serialValid;
  logic       frameStart;
  logic [7:0] parallelDataOut;
  logic       parallelValid;
  logic       parallelReady;
  logic       busy;
  logic       frameError;
  logic       overrunError;
  logic       clearErrors;

  int n_checks = 0;
  int n_bad    = 0;

  serial_to_parallel_converter #(.DATA_WIDTH(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .serialDataIn    (serialDataIn),
    .serialValid     (serialValid),
    .frameStart      (frameStart),
    .parallelDataOut (parallelDataOut),
    .parallelValid   (parallelValid),
    .parallelReady   (parallelReady),
    .busy            (busy),
    .frameError      (frameError),
    .overrunError    (overrunError),
    .clearErrors     (clearErrors)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply one cycle of inputs at a negedge; returns at the next negedge with outputs settled.
  task automatic drive(input logic v, input logic d, input logic fs, input logic rdy, input logic clr);
    serialValid   = v;
    serialDataIn  = d;
    frameStart    = fs;
    parallelReady = rdy;
    clearErrors   = clr;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy);
    for (int i = 7; i >= 0; i--) drive(1'b1, w[i], i == 7, rdy, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    logic [7:0] w;
    reset = 1'b0;
    serialDataIn = 1'b0; serialValid = 1'b0; frameStart = 1'b0;
    parallelReady = 1'b0; clearErrors = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", parallelValid, 0);
    check("rst_data",  parallelDataOut, 0);
    check("rst_busy",  busy, 0);
    check("rst_flags", {frameError, overrunError}, 0);
    reset = 1'b1;
    @(negedge clk);

    // 0xA5, contiguous strobes; busy across bits 1..7, valid one cycle after bit 8
    w = 8'hA5;
    for (int i = 7; i >= 1; i--) begin
      drive(1'b1, w[i], i == 7, 1'b1, 1'b0);
      check($sformatf("a5_busy_bit%0d", 8 - i), busy, 1);
      check($sformatf("a5_novalid_bit%0d", 8 - i), parallelValid, 0);
    end
    drive(1'b1, w[0], 1'b0, 1'b1, 1'b0);
    check("a5_valid", parallelValid, 1);
    check("a5_data",  parallelDataOut, 8'hA5);
    check("a5_busy_done", busy, 0);
    idle(1'b1);
    check("a5_valid_1cyc", parallelValid, 0);
    check("a5_data_hold", parallelDataOut, 8'hA5);

    // 0x3C with strobes every 3rd cycle; non-strobe cycles carry a 1
    w = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      drive(1'b1, w[i], i == 7, 1'b1, 1'b0);
      if (i != 0) begin
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      end
    end
    check("3c_valid", parallelValid, 1);
    check("3c_data",  parallelDataOut, 8'h3C);
    idle(1'b1);

    // 4 bits, then a resync (with clearErrors the same cycle; set wins), then 0xFF
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("fe_before", frameError, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("fe_set_prio", frameError, 1);
    check("fe_busy", busy, 1);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("fe_valid", parallelValid, 1);
    check("fe_data",  parallelDataOut, 8'hFF);
    check("fe_sticky", frameError, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("fe_cleared", frameError, 0);
    check("fe_drained", parallelValid, 0);

    // Back-to-back 0x12, 0x34 with no consumer: second word dropped
    send_word(8'h12, 1'b0);
    check("ov_first_valid", parallelValid, 1);
    check("ov_first_data",  parallelDataOut, 8'h12);
    send_word(8'h34, 1'b0);
    check("ov_flag",  overrunError, 1);
    check("ov_held",  parallelDataOut, 8'h12);
    check("ov_valid", parallelValid, 1);
    idle(1'b1);
    check("ov_accept_valid", parallelValid, 0);
    check("ov_accept_data",  parallelDataOut, 8'h12);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ov_cleared", overrunError, 0);

    // Same again, but the consumer drains on the completion edge of 0x34
    send_word(8'h12, 1'b0);
    w = 8'h34;
    for (int i = 7; i >= 0; i--) drive(1'b1, w[i], i == 7, i == 0, 1'b0);
    check("sw_no_ovr", overrunError, 0);
    check("sw_valid",  parallelValid, 1);
    check("sw_data",   parallelDataOut, 8'h34);
    idle(1'b1);
    check("sw_drained", parallelValid, 0);

    // Async reset mid-word with a pending output word and frameError set
    send_word(8'h55, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    w = 8'h81;
    for (int i = 7; i >= 3; i--) drive(1'b1, w[i], i == 7, 1'b0, 1'b0);
    check("ar_pre_valid", parallelValid, 1);
    check("ar_pre_fe", frameError, 1);
    check("ar_pre_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("ar_valid", parallelValid, 0);
    check("ar_data",  parallelDataOut, 0);
    check("ar_busy",  busy, 0);
    check("ar_flags", {frameError, overrunError}, 0);
    @(negedge clk);
    reset = 1'b1;
    send_word(8'h81, 1'b1);
    check("ar_new_valid", parallelValid, 1);
    check("ar_new_data",  parallelDataOut, 8'h81);
    idle(1'b1);

    // Unframed bits while IDLE are ignored; next framed word intact
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      check($sformatf("uf_busy%0d", i), busy, 0);
      check($sformatf("uf_valid%0d", i), parallelValid, 0);
    end
    send_word(8'h7E, 1'b1);
    check("uf_valid", parallelValid, 1);
    check("uf_data",  parallelDataOut, 8'h7E);
    check("uf_no_fe", frameError, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
